// File: rtl/req_queue_3ch_pkg.sv
// Shared definitions for the three-channel request queue and its arbiter bench.
package req_queue_3ch_pkg;

   localparam int NUM_CH = 3;

   typedef logic [1:0] src_t;

   function automatic src_t onehot_to_idx(input logic [NUM_CH-1:0] oh);
      src_t idx;
      idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (oh[i]) idx = src_t'(i);
      end
      return idx;
   endfunction

   // Zero or exactly one bit set counts as legal; an idle arbiter drives all zeros.
   function automatic logic grant_legal(input logic [NUM_CH-1:0] v);
      return (v & (v - 1'b1)) == '0;
   endfunction

endpackage

// File: rtl/req_queue_3ch_if.sv
// Bundle of push-side, arbiter-side and output-side signals of req_queue_3ch.
interface req_queue_3ch_if #(parameter int DW = 8);
   import req_queue_3ch_pkg::*;

   logic [NUM_CH-1:0]    push;
   logic [NUM_CH*DW-1:0] push_data;
   logic [NUM_CH-1:0]    full;
   logic [NUM_CH-1:0]    req;
   logic [NUM_CH-1:0]    gnt;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   src_t                 out_src;
   logic [NUM_CH-1:0]    ovf;
   logic                 gnt_err;

   modport master (
      output push, push_data, gnt,
      input  full, req, out_valid, out_data, out_src, ovf, gnt_err
   );

   modport slave (
      input  push, push_data, gnt,
      output full, req, out_valid, out_data, out_src, ovf, gnt_err
   );

endinterface

// File: rtl/req_queue_3ch_chan_fifo.sv
// Single-channel FIFO with combinational head, count-based flags and sticky overflow.
module chan_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic          ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic          wr_ok, rd_ok;

   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   // A push into a full FIFO is dropped even when the same cycle pops.
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      if (wr_ok && !rd_ok)      count_next = count_reg + 1'b1;
      else if (!wr_ok && rd_ok) count_next = count_reg - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf        <= 1'b0;
      end else begin
         if (wr_ok)          wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_ok)          rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (wr_en && full)  ovf        <= 1'b1;
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/req_queue_3ch.sv
// Per-channel request buffering in front of the round-robin arbiter; pops on grant.
module req_queue_3ch
   import req_queue_3ch_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   req_queue_3ch_if.slave bus
);
   logic [DW-1:0]     head [NUM_CH];
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] pop;
   logic              legal;
   logic              valid_gnt;
   src_t              gnt_idx;

   assign legal     = grant_legal(bus.gnt);
   // Grants to empty channels are idle grants and simply ignored.
   assign valid_gnt = legal && |(bus.gnt & bus.req);
   assign gnt_idx   = onehot_to_idx(bus.gnt);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign pop[gi]     = valid_gnt && bus.gnt[gi];
         assign bus.req[gi] = !empty[gi];

         chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bus.push[gi]),
            .wr_data (bus.push_data[gi*DW +: DW]),
            .rd_en   (pop[gi]),
            .rd_data (head[gi]),
            .full    (bus.full[gi]),
            .empty   (empty[gi]),
            .ovf     (bus.ovf[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
         bus.gnt_err   <= 1'b0;
      end else begin
         bus.out_valid <= valid_gnt;
         if (valid_gnt) begin
            bus.out_data <= head[gnt_idx];
            bus.out_src  <= gnt_idx;
         end
         if (!legal) bus.gnt_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_req_queue_3ch.sv
// Directed self-checking bench for req_queue_3ch with DW = 8, DEPTH = 4.
module tb_req_queue_3ch;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   req_queue_3ch_if #(.DW(8)) bus ();

   req_queue_3ch #(.DW(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] p, input logic [23:0] d, input logic [2:0] g);
      bus.push      = p;
      bus.push_data = d;
      bus.gnt       = g;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(3'b000, 24'h0, 3'b000);
      tick();
      tick();
      checks++; if (bus.req !== 3'b000) begin errors++; $display("FAIL reset_req got %b exp 000", bus.req); end
      checks++; if (bus.full !== 3'b000) begin errors++; $display("FAIL reset_full got %b exp 000", bus.full); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
      checks++; if (bus.out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got %0d exp 0", bus.out_src); end
      checks++; if (bus.ovf !== 3'b000) begin errors++; $display("FAIL reset_ovf got %b exp 000", bus.ovf); end
      checks++; if (bus.gnt_err !== 1'b0) begin errors++; $display("FAIL reset_gnt_err got %b exp 0", bus.gnt_err); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_push_req();
      drive(3'b001, 24'h000011, 3'b000);
      tick();
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.req !== 3'b001) begin errors++; $display("FAIL push_req got %b exp 001", bus.req); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL push_no_valid got %b exp 0", bus.out_valid); end
      drive(3'b000, 24'h0, 3'b001);
      tick();
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_src !== 2'd0)
         begin errors++; $display("FAIL pop_ch0 got v=%b d=%h s=%0d exp v=1 d=11 s=0", bus.out_valid, bus.out_data, bus.out_src); end
      checks++; if (bus.req !== 3'b000) begin errors++; $display("FAIL pop_ch0_req got %b exp 000", bus.req); end
   endtask

   task automatic test_two_pops();
      drive(3'b010, 24'h00A100, 3'b000); tick();
      drive(3'b010, 24'h00A200, 3'b000); tick();
      drive(3'b000, 24'h0, 3'b010); tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1 || bus.out_src !== 2'd1 || bus.req !== 3'b010)
         begin errors++; $display("FAIL pop1_ch1 got v=%b d=%h s=%0d req=%b exp v=1 d=a1 s=1 req=010", bus.out_valid, bus.out_data, bus.out_src, bus.req); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA2 || bus.out_src !== 2'd1 || bus.req !== 3'b000)
         begin errors++; $display("FAIL pop2_ch1 got v=%b d=%h s=%0d req=%b exp v=1 d=a2 s=1 req=000", bus.out_valid, bus.out_data, bus.out_src, bus.req); end
      drive(3'b000, 24'h0, 3'b000); tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA2 || bus.out_src !== 2'd1)
         begin errors++; $display("FAIL idle_hold got v=%b d=%h s=%0d exp v=0 d=a2 s=1", bus.out_valid, bus.out_data, bus.out_src); end
   endtask

   task automatic test_overflow();
      logic [7:0] vals [5];
      vals = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
      for (int i = 0; i < 5; i++) begin
         drive(3'b100, {vals[i], 16'h0}, 3'b000);
         tick();
         if (i == 3) begin
            checks++; if (bus.full !== 3'b100 || bus.ovf !== 3'b000)
               begin errors++; $display("FAIL full_after4 got full=%b ovf=%b exp full=100 ovf=000", bus.full, bus.ovf); end
         end
      end
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.full !== 3'b100 || bus.ovf !== 3'b100)
         begin errors++; $display("FAIL ovf_after5 got full=%b ovf=%b exp full=100 ovf=100", bus.full, bus.ovf); end
      for (int i = 0; i < 4; i++) begin
         drive(3'b000, 24'h0, 3'b100);
         tick();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i] || bus.out_src !== 2'd2)
            begin errors++; $display("FAIL drain_ch2[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=2", i, bus.out_valid, bus.out_data, bus.out_src, vals[i]); end
      end
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.req !== 3'b000 || bus.full !== 3'b000)
         begin errors++; $display("FAIL drain_ch2_end got req=%b full=%b exp req=000 full=000", bus.req, bus.full); end
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] exp_q [6];
      exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      drive(3'b001, 24'h0000B0, 3'b000); tick();
      drive(3'b001, 24'h0000B1, 3'b000); tick();
      // Ch0 pointers start at 1 from the earlier test, so these wrap both pointers.
      for (int i = 0; i < 4; i++) begin
         drive(3'b001, {16'h0, exp_q[i+2]}, 3'b001);
         tick();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i] || bus.req !== 3'b001 || bus.full !== 3'b000)
            begin errors++; $display("FAIL pushpop[%0d] got v=%b d=%h req=%b full=%b exp v=1 d=%h req=001 full=000", i, bus.out_valid, bus.out_data, bus.req, bus.full, exp_q[i]); end
      end
      for (int i = 4; i < 6; i++) begin
         drive(3'b000, 24'h0, 3'b001);
         tick();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i])
            begin errors++; $display("FAIL pushpop_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, exp_q[i]); end
      end
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.req !== 3'b000) begin errors++; $display("FAIL pushpop_empty got req=%b exp 000", bus.req); end
   endtask

   task automatic test_grants();
      drive(3'b011, 24'h00C1C0, 3'b000); tick();
      drive(3'b000, 24'h0, 3'b100); tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.gnt_err !== 1'b0 || bus.req !== 3'b011)
         begin errors++; $display("FAIL empty_gnt got v=%b err=%b req=%b exp v=0 err=0 req=011", bus.out_valid, bus.gnt_err, bus.req); end
      drive(3'b000, 24'h0, 3'b011); tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.gnt_err !== 1'b1 || bus.req !== 3'b011)
         begin errors++; $display("FAIL illegal_gnt got v=%b err=%b req=%b exp v=0 err=1 req=011", bus.out_valid, bus.gnt_err, bus.req); end
      drive(3'b000, 24'h0, 3'b000); tick(); tick();
      checks++; if (bus.gnt_err !== 1'b1) begin errors++; $display("FAIL gnt_err_sticky got %b exp 1", bus.gnt_err); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         drive(3'b100, 24'hD00000 | (24'(i) << 16), 3'b000);
         tick();
      end
      drive(3'b000, 24'h0, 3'b001); tick();
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0 || bus.full !== 3'b100 || bus.req !== 3'b110)
         begin errors++; $display("FAIL pre_reset got v=%b d=%h full=%b req=%b exp v=1 d=c0 full=100 req=110", bus.out_valid, bus.out_data, bus.full, bus.req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.req !== 3'b000 || bus.full !== 3'b000 || bus.out_valid !== 1'b0 || bus.ovf !== 3'b000 || bus.gnt_err !== 1'b0)
         begin errors++; $display("FAIL async_reset got req=%b full=%b v=%b ovf=%b err=%b exp all 0", bus.req, bus.full, bus.out_valid, bus.ovf, bus.gnt_err); end
      tick();
      rst_n = 1'b1;
      tick();
      drive(3'b010, 24'h00E100, 3'b000); tick();
      drive(3'b000, 24'h0, 3'b010); tick();
      drive(3'b000, 24'h0, 3'b000);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE1 || bus.out_src !== 2'd1 || bus.req !== 3'b000)
         begin errors++; $display("FAIL post_reset_pop got v=%b d=%h s=%0d req=%b exp v=1 d=e1 s=1 req=000", bus.out_valid, bus.out_data, bus.out_src, bus.req); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_push_req();
      test_two_pops();
      test_overflow();
      test_simul_push_pop();
      test_grants();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
